// File: rtl/pc_fetch_unit.sv
// Fetch-stage PC generator: sequential/branch/jump/exception targets, SRAM
// request handshake, stall handling and a one-entry buffer for blocked redirects.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VEC = 32'hbfc00000,
  parameter logic [31:0] EXC_VEC   = 32'hbfc00380,
  parameter int unsigned PC_STEP   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ctrl_valid,
  input  logic        is_b,
  input  logic        is_j,
  input  logic        is_jr,
  input  logic [2:0]  b_type,
  input  logic [15:0] b_offset,
  input  logic [25:0] j_index,
  input  logic [31:0] rdata1,
  input  logic [31:0] rdata2,
  input  logic        exc,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        stall,
  input  logic        inst_addr_ok,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  output logic [31:0] pc,
  output logic        b_taken,
  output logic        redir_pend
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [31:0] STEP = PC_STEP[31:0];

  state_t      state;
  state_t      state_next;
  logic [31:0] pend_pc;
  logic [31:0] pc_next;
  logic [31:0] pend_pc_next;
  logic        redir_pend_next;
  logic        inst_req_next;

  logic        cond;
  logic        rs_neg;
  logic        rs_zero;
  logic        take_jr;
  logic        take_j;
  logic        redirect;
  logic        adv;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] seq_target;
  logic [31:0] redir_target;

  assign rs_neg  = rdata1[31];
  assign rs_zero = (rdata1 == 32'd0);

  // Branch condition decode; codes 6-7 are never taken
  always_comb begin
    cond = 1'b0;
    case (b_type)
      3'd0:    cond = (rdata1 != rdata2);
      3'd1:    cond = (rdata1 == rdata2);
      3'd2:    cond = ~rs_neg;
      3'd3:    cond = ~rs_neg & ~rs_zero;
      3'd4:    cond = rs_neg | rs_zero;
      3'd5:    cond = rs_neg;
      default: cond = 1'b0;
    endcase
  end

  assign b_taken    = ctrl_valid & is_b & cond;
  assign take_jr    = ctrl_valid & is_jr;
  assign take_j     = ctrl_valid & is_j;
  assign redirect   = eret | b_taken | take_jr | take_j;
  assign adv        = inst_req & inst_addr_ok & ~stall;

  assign br_target  = pc + {{14{b_offset[15]}}, b_offset, 2'b00};
  assign j_target   = {pc[31:28], j_index, 2'b00};
  assign seq_target = pc + STEP;

  assign inst_addr  = pc;

  // Redirect target mux, highest priority first (exception handled separately)
  always_comb begin
    redir_target = seq_target;
    if (eret) begin
      redir_target = epc;
    end else if (b_taken) begin
      redir_target = br_target;
    end else if (take_jr) begin
      redir_target = rdata1;
    end else if (take_j) begin
      redir_target = j_target;
    end else begin
      redir_target = seq_target;
    end
  end

  // Next PC, pending-redirect buffer and state
  always_comb begin
    state_next      = state;
    pc_next         = pc;
    pend_pc_next    = pend_pc;
    redir_pend_next = redir_pend;
    if (exc) begin
      pc_next         = EXC_VEC;
      pend_pc_next    = 32'd0;
      redir_pend_next = 1'b0;
      state_next      = RUN;
    end else if (redirect) begin
      if (adv) begin
        pc_next         = redir_target;
        pend_pc_next    = 32'd0;
        redir_pend_next = 1'b0;
        state_next      = RUN;
      end else begin
        // Youngest redirect overwrites any older buffered one
        pend_pc_next    = redir_target;
        redir_pend_next = 1'b1;
        state_next      = HOLD;
      end
    end else if (adv) begin
      if (redir_pend) begin
        pc_next = pend_pc;
      end else begin
        pc_next = seq_target;
      end
      pend_pc_next    = 32'd0;
      redir_pend_next = 1'b0;
      state_next      = RUN;
    end else begin
      if (state == BOOT) begin
        state_next = RUN;
      end else begin
        state_next = state;
      end
    end
    inst_req_next = (state_next != BOOT);
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= BOOT;
      pc         <= RESET_VEC;
      pend_pc    <= 32'd0;
      redir_pend <= 1'b0;
      inst_req   <= 1'b0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      pend_pc    <= pend_pc_next;
      redir_pend <= redir_pend_next;
      inst_req   <= inst_req_next;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed table-driven bench for pc_fetch_unit plus a reset-during-HOLD sequence.
module tb_pc_fetch_unit;

  logic        clk;
  logic        reset;
  logic        ctrl_valid;
  logic        is_b;
  logic        is_j;
  logic        is_jr;
  logic [2:0]  b_type;
  logic [15:0] b_offset;
  logic [25:0] j_index;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        exc;
  logic        eret;
  logic [31:0] epc;
  logic        stall;
  logic        inst_addr_ok;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] pc;
  logic        b_taken;
  logic        redir_pend;

  int total = 0;
  int bad   = 0;

  pc_fetch_unit dut (
    .clk(clk), .reset(reset), .ctrl_valid(ctrl_valid), .is_b(is_b), .is_j(is_j),
    .is_jr(is_jr), .b_type(b_type), .b_offset(b_offset), .j_index(j_index),
    .rdata1(rdata1), .rdata2(rdata2), .exc(exc), .eret(eret), .epc(epc),
    .stall(stall), .inst_addr_ok(inst_addr_ok), .inst_req(inst_req),
    .inst_addr(inst_addr), .pc(pc), .b_taken(b_taken), .redir_pend(redir_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        cv, ib, ij, ijr;
    logic [2:0]  bt;
    logic [15:0] off;
    logic [25:0] ji;
    logic [31:0] r1, r2;
    logic        ex, er;
    logic [31:0] ep;
    logic        st, ok;
    logic        e_bt;
    logic [31:0] e_pc;
    logic        e_pend;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t nop(logic ok, logic st, logic [31:0] e_pc, logic e_pend);
    vec_t v;
    v.cv = 1'b0; v.ib = 1'b0; v.ij = 1'b0; v.ijr = 1'b0;
    v.bt = 3'd0; v.off = 16'h0000; v.ji = 26'h0; v.r1 = 32'h0; v.r2 = 32'h0;
    v.ex = 1'b0; v.er = 1'b0; v.ep = 32'h0; v.st = st; v.ok = ok;
    v.e_bt = 1'b0; v.e_pc = e_pc; v.e_pend = e_pend;
    return v;
  endfunction

  function automatic vec_t br(logic [2:0] t, logic [15:0] off, logic [31:0] a, logic [31:0] b,
                              logic e_bt, logic [31:0] e_pc);
    vec_t v;
    v = nop(1'b1, 1'b0, e_pc, 1'b0);
    v.cv = 1'b1; v.ib = 1'b1; v.bt = t; v.off = off; v.r1 = a; v.r2 = b; v.e_bt = e_bt;
    return v;
  endfunction

  function automatic vec_t jmp(logic [25:0] ji, logic ok, logic st, logic [31:0] e_pc, logic e_pend);
    vec_t v;
    v = nop(ok, st, e_pc, e_pend);
    v.cv = 1'b1; v.ij = 1'b1; v.ji = ji;
    return v;
  endfunction

  function automatic vec_t jreg(logic [31:0] a, logic ok, logic st, logic [31:0] e_pc, logic e_pend);
    vec_t v;
    v = nop(ok, st, e_pc, e_pend);
    v.cv = 1'b1; v.ijr = 1'b1; v.r1 = a;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(vec_t v);
    ctrl_valid = v.cv; is_b = v.ib; is_j = v.ij; is_jr = v.ijr;
    b_type = v.bt; b_offset = v.off; j_index = v.ji; rdata1 = v.r1; rdata2 = v.r2;
    exc = v.ex; eret = v.er; epc = v.ep; stall = v.st; inst_addr_ok = v.ok;
  endtask

  initial begin
    vec_t v;

    // Boot and sequential fetch
    vecs.push_back(nop(1'b1, 1'b0, 32'hbfc00000, 1'b0));
    vecs.push_back(nop(1'b1, 1'b0, 32'hbfc00004, 1'b0));
    vecs.push_back(nop(1'b1, 1'b0, 32'hbfc00008, 1'b0));
    vecs.push_back(nop(1'b1, 1'b0, 32'hbfc0000c, 1'b0));
    vecs.push_back(nop(1'b1, 1'b0, 32'hbfc00010, 1'b0));
    vecs.push_back(br(3'd1, 16'hfffc, 32'd5, 32'd5, 1'b1, 32'hbfc00000));
    vecs.push_back(nop(1'b1, 1'b0, 32'hbfc00004, 1'b0));
    vecs.push_back(nop(1'b1, 1'b0, 32'hbfc00008, 1'b0));
    vecs.push_back(nop(1'b1, 1'b0, 32'hbfc0000c, 1'b0));
    vecs.push_back(nop(1'b1, 1'b0, 32'hbfc00010, 1'b0));
    vecs.push_back(br(3'd5, 16'hfffc, 32'd0, 32'd0, 1'b0, 32'hbfc00014));
    vecs.push_back(nop(1'b1, 1'b1, 32'hbfc00014, 1'b0));
    vecs.push_back(nop(1'b1, 1'b0, 32'hbfc00018, 1'b0));
    vecs.push_back(nop(1'b1, 1'b0, 32'hbfc0001c, 1'b0));
    vecs.push_back(nop(1'b1, 1'b0, 32'hbfc00020, 1'b0));
    // J blocked by addr_ok for three cycles
    vecs.push_back(jmp(26'h0000100, 1'b0, 1'b0, 32'hbfc00020, 1'b1));
    vecs.push_back(nop(1'b0, 1'b0, 32'hbfc00020, 1'b1));
    vecs.push_back(nop(1'b0, 1'b0, 32'hbfc00020, 1'b1));
    vecs.push_back(nop(1'b1, 1'b0, 32'hb0000400, 1'b0));
    // Exception in HOLD under stall
    vecs.push_back(jmp(26'h0000100, 1'b0, 1'b0, 32'hb0000400, 1'b1));
    v = nop(1'b0, 1'b1, 32'hbfc00380, 1'b0); v.ex = 1'b1; vecs.push_back(v);
    vecs.push_back(nop(1'b1, 1'b0, 32'hbfc00384, 1'b0));
    // ERET beats a taken branch
    v = br(3'd1, 16'h0001, 32'd0, 32'd0, 1'b1, 32'h80001234); v.er = 1'b1; v.ep = 32'h80001234;
    vecs.push_back(v);
    // Unaligned JR passes through
    vecs.push_back(jreg(32'h12345679, 1'b1, 1'b0, 32'h12345679, 1'b0));
    vecs.push_back(br(3'd2, 16'h0004, 32'hffffffff, 32'd0, 1'b0, 32'h1234567d));
    vecs.push_back(br(3'd3, 16'h0004, 32'h00000001, 32'd0, 1'b1, 32'h1234568d));
    vecs.push_back(br(3'd4, 16'h0001, 32'h00000000, 32'd0, 1'b1, 32'h12345691));
    vecs.push_back(br(3'd5, 16'h0000, 32'h80000000, 32'd0, 1'b1, 32'h12345691));
    vecs.push_back(br(3'd6, 16'h0004, 32'h00000000, 32'd0, 1'b0, 32'h12345695));
    // Two redirects while stalled: youngest wins
    vecs.push_back(jreg(32'h00001000, 1'b1, 1'b1, 32'h12345695, 1'b1));
    vecs.push_back(jmp(26'h3ffffff, 1'b1, 1'b1, 32'h12345695, 1'b1));
    vecs.push_back(nop(1'b1, 1'b0, 32'h1ffffffc, 1'b0));
    vecs.push_back(br(3'd1, 16'h7fff, 32'd7, 32'd7, 1'b1, 32'h2001fff8));
    v = br(3'd1, 16'h0004, 32'd7, 32'd7, 1'b0, 32'h2001fffc); v.cv = 1'b0; vecs.push_back(v);
    // Priority jr over j, branch over jr
    v = jreg(32'h00000100, 1'b1, 1'b0, 32'h00000100, 1'b0); v.ij = 1'b1; v.ji = 26'h0; vecs.push_back(v);
    v = br(3'd1, 16'h0001, 32'h00005000, 32'h00005000, 1'b1, 32'h00000104); v.ijr = 1'b1; vecs.push_back(v);
    vecs.push_back(br(3'd0, 16'hfffe, 32'd1, 32'd2, 1'b1, 32'h000000fc));
    vecs.push_back(br(3'd0, 16'hfffe, 32'd3, 32'd3, 1'b0, 32'h00000100));

    apply(nop(1'b1, 1'b0, 32'h0, 1'b0));
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset pc", pc, 32'hbfc00000);
    chk("reset inst_addr", inst_addr, 32'hbfc00000);
    chk("reset inst_req", {31'd0, inst_req}, 32'd0);
    chk("reset redir_pend", {31'd0, redir_pend}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
      #1;
      chk($sformatf("row%0d b_taken", i), {31'd0, b_taken}, {31'd0, vecs[i].e_bt});
      @(posedge clk);
      #1;
      chk($sformatf("row%0d pc", i), pc, vecs[i].e_pc);
      chk($sformatf("row%0d inst_addr", i), inst_addr, vecs[i].e_pc);
      chk($sformatf("row%0d redir_pend", i), {31'd0, redir_pend}, {31'd0, vecs[i].e_pend});
      chk($sformatf("row%0d inst_req", i), {31'd0, inst_req}, 32'd1);
      @(negedge clk);
    end

    // Reset while a redirect is buffered discards it
    apply(jmp(26'h0000200, 1'b0, 1'b0, 32'h0, 1'b0));
    @(posedge clk);
    #1;
    chk("hold pc", pc, 32'h00000100);
    chk("hold redir_pend", {31'd0, redir_pend}, 32'd1);
    @(negedge clk);
    apply(nop(1'b1, 1'b0, 32'h0, 1'b0));
    reset = 1'b1;
    #1;
    chk("midhold reset pc", pc, 32'hbfc00000);
    chk("midhold reset inst_req", {31'd0, inst_req}, 32'd0);
    chk("midhold reset redir_pend", {31'd0, redir_pend}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post reset boot pc", pc, 32'hbfc00000);
    chk("post reset inst_req", {31'd0, inst_req}, 32'd1);
    @(posedge clk);
    #1;
    chk("post reset seq pc", pc, 32'hbfc00004);
    chk("post reset redir_pend", {31'd0, redir_pend}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
